// File: rtl/sprite_compositor_pkg.sv
// rtl/sprite_compositor_pkg.sv - shared types, colours and palette contents for the sprite compositor
//
// Package sprite_pkg: screen_state_t, rgb_t, fixed colours and the
// palette_entry() function that defines the contents of every palette ROM.
package sprite_pkg;

    typedef logic [23:0] rgb_t;

    typedef enum logic [2:0] {
        TITLE     = 3'd0,
        TITLE_GO  = 3'd1,
        GAME      = 3'd2,
        GAME_OVER = 3'd3,
        ROUND_END = 3'd4
    } screen_state_t;

    localparam rgb_t KEY_COLOR = 24'hF442EE;
    localparam rgb_t BG_SKY    = 24'h0000F0;
    localparam rgb_t BG_TITLE  = 24'h00F0F0;
    localparam rgb_t RGB_WHITE = 24'hFFFFFF;
    localparam rgb_t RGB_BLACK = 24'h000000;

    // Index 0 is the transparent key; every other index yields a colour whose
    // green byte is idx^0x80 and blue byte is ~idx, which can never equal KEY_COLOR.
    function automatic rgb_t palette_entry(input logic [7:0] idx);
        if (idx == 8'd0) begin
            return KEY_COLOR;
        end
        return {idx, idx ^ 8'h80, ~idx};
    endfunction

endpackage

// File: rtl/sprite_compositor_if.sv
// rtl/sprite_compositor_if.sv - pixel-in / RGB-out bundle of the sprite compositor
//
// Signals: pix_valid, frame_start, state[2:0], layer_hit[NUM_LAYERS],
// layer_idx[NUM_LAYERS*IDX_W] (slice i = layer i), is_cursor, shot (inputs to
// the compositor); VGA_R/G/B[7:0], out_valid (outputs of the compositor).
// master: pixel source side. slave: the compositor.
interface sprite_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int IDX_W      = 4
);
    logic                        pix_valid;
    logic                        frame_start;
    logic [2:0]                  state;
    logic [NUM_LAYERS-1:0]       layer_hit;
    logic [NUM_LAYERS*IDX_W-1:0] layer_idx;
    logic                        is_cursor;
    logic                        shot;
    logic [7:0]                  VGA_R;
    logic [7:0]                  VGA_G;
    logic [7:0]                  VGA_B;
    logic                        out_valid;

    modport master (
        output pix_valid, frame_start, state, layer_hit, layer_idx, is_cursor, shot,
        input  VGA_R, VGA_G, VGA_B, out_valid
    );

    modport slave (
        input  pix_valid, frame_start, state, layer_hit, layer_idx, is_cursor, shot,
        output VGA_R, VGA_G, VGA_B, out_valid
    );
endinterface

// File: rtl/sprite_compositor_palette_lut.sv
// rtl/sprite_compositor_palette_lut.sv - synchronous palette ROM, one-cycle read latency
//
// Module palette_lut. Ports: clk_i (clock), idx_i[IDX_W] (palette index),
// rgb_o (colour of idx_i registered on the rising edge).
module palette_lut
    import sprite_pkg::*;
#(
    parameter int IDX_W = 4
) (
    input  logic             clk_i,
    input  logic [IDX_W-1:0] idx_i,
    output rgb_t             rgb_o
);
    localparam int DEPTH = 1 << IDX_W;

    rgb_t rom [DEPTH];
    rgb_t rgb_q;

    for (genvar i = 0; i < DEPTH; i++) begin : g_rom
        assign rom[i] = palette_entry(8'(i));
    end

    always_ff @(posedge clk_i) begin
        rgb_q <= rom[idx_i];
    end

    assign rgb_o = rgb_q;
endmodule

// File: rtl/sprite_compositor.sv
// rtl/sprite_compositor.sv - three-stage sprite layer compositor with cursor and shot flash
//
// Ports: Clk (rising edge), Reset_n (async active-low), bus (sprite_compositor_if.slave:
// pixel inputs in, registered VGA_R/G/B and out_valid out, 3 cycles after pix_valid).
// Stage 1 registers inputs, stage 2 reads all palettes in parallel, stage 3 selects
// and registers the colour. Define SPRITE_COMPOSITOR_FLASH_EN to add the hit-detect
// flash that turns opaque pixels white for FLASH_FRAMES frames after a shot edge.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int IDX_W        = 4,
    parameter int FLASH_FRAMES = 2
) (
    input  logic              Clk,
    input  logic              Reset_n,
    sprite_compositor_if.slave bus
);
    // Stage 1 registers
    logic                        v1_q, cur1_q, shot1_q, flash1_q;
    logic [2:0]                  state1_q;
    logic [NUM_LAYERS-1:0]       hit1_q;
    logic [NUM_LAYERS*IDX_W-1:0] idx1_q;
    // Stage 2 registers (palette colours come from the LUT instances)
    logic                        v2_q, cur2_q, shot2_q, flash2_q;
    logic [2:0]                  state2_q;
    logic [NUM_LAYERS-1:0]       hit2_q;
    rgb_t                        col2 [NUM_LAYERS];
    // Stage 3 registers
    logic                        out_valid_q;
    rgb_t                        rgb_q, rgb_d;
    logic                        flash_in;
    logic                        any_opaque;
    rgb_t                        layer_rgb;

`ifdef SPRITE_COMPOSITOR_FLASH_EN
    localparam int CNT_W = $clog2(FLASH_FRAMES + 1);

    logic [CNT_W-1:0] flash_cnt_q, flash_cnt_d;
    logic             shot_prev_q;
    logic             shot_rise;

    // The counter value after this pixel's update governs this pixel, so the
    // first pixel of the frame that decrements the count to zero is already normal.
    always_comb begin
        shot_rise   = bus.pix_valid && bus.shot && !shot_prev_q;
        flash_cnt_d = flash_cnt_q;
        if (shot_rise) begin
            flash_cnt_d = CNT_W'(FLASH_FRAMES);
        end else if (bus.frame_start && (flash_cnt_q != '0)) begin
            flash_cnt_d = flash_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            flash_cnt_q <= '0;
            shot_prev_q <= 1'b0;
        end else begin
            flash_cnt_q <= flash_cnt_d;
            if (bus.pix_valid) begin
                shot_prev_q <= bus.shot;
            end
        end
    end

    assign flash_in = (flash_cnt_d != '0);
`else
    assign flash_in = 1'b0;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            v1_q     <= 1'b0;
            cur1_q   <= 1'b0;
            shot1_q  <= 1'b0;
            flash1_q <= 1'b0;
            state1_q <= TITLE;
            hit1_q   <= '0;
            idx1_q   <= '0;
            v2_q     <= 1'b0;
            cur2_q   <= 1'b0;
            shot2_q  <= 1'b0;
            flash2_q <= 1'b0;
            state2_q <= TITLE;
            hit2_q   <= '0;
        end else begin
            v1_q     <= bus.pix_valid;
            cur1_q   <= bus.is_cursor;
            shot1_q  <= bus.shot;
            flash1_q <= flash_in;
            state1_q <= bus.state;
            hit1_q   <= bus.layer_hit;
            idx1_q   <= bus.layer_idx;
            v2_q     <= v1_q;
            cur2_q   <= cur1_q;
            shot2_q  <= shot1_q;
            flash2_q <= flash1_q;
            state2_q <= state1_q;
            hit2_q   <= hit1_q;
        end
    end

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_layer
        palette_lut #(.IDX_W(IDX_W)) u_lut (
            .clk_i (Clk),
            .idx_i (idx1_q[g*IDX_W +: IDX_W]),
            .rgb_o (col2[g])
        );
    end

    always_comb begin
        rgb_d      = RGB_BLACK;
        any_opaque = 1'b0;
        layer_rgb  = BG_SKY;
        // Scan from the highest index down so the lowest-numbered opaque layer wins.
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit2_q[i] && (col2[i] != KEY_COLOR)) begin
                any_opaque = 1'b1;
                layer_rgb  = col2[i];
            end
        end
        if (v2_q) begin
            case (state2_q)
                TITLE: rgb_d = BG_TITLE;
                TITLE_GO, GAME, ROUND_END: begin
                    if (cur2_q) begin
                        rgb_d = shot2_q ? RGB_BLACK : RGB_WHITE;
                    end else if (flash2_q) begin
                        rgb_d = any_opaque ? RGB_WHITE : RGB_BLACK;
                    end else begin
                        rgb_d = layer_rgb;
                    end
                end
                default: rgb_d = RGB_BLACK;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            out_valid_q <= 1'b0;
            rgb_q       <= RGB_BLACK;
        end else begin
            out_valid_q <= v2_q;
            rgb_q       <= rgb_d;
        end
    end

    assign bus.VGA_R     = rgb_q[23:16];
    assign bus.VGA_G     = rgb_q[15:8];
    assign bus.VGA_B     = rgb_q[7:0];
    assign bus.out_valid = out_valid_q;
endmodule

// File: tb/tb_sprite_compositor.sv
// tb/tb_sprite_compositor.sv - randomized self-checking bench for sprite_compositor
module tb_sprite_compositor;
    import sprite_pkg::*;

    localparam int NL = 4;
    localparam int IW = 4;
    localparam int FF = 2;

    logic Clk     = 1'b0;
    logic Reset_n = 1'b1;

    always #5 Clk = ~Clk;

    sprite_compositor_if #(.NUM_LAYERS(NL), .IDX_W(IW)) bus ();

    sprite_compositor #(.NUM_LAYERS(NL), .IDX_W(IW), .FLASH_FRAMES(FF)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        bit          v;
        logic [23:0] rgb;
    } exp_t;

    exp_t expq[$];
    int   flash_cnt = 0;
    bit   shot_prev = 1'b0;

    function automatic logic [23:0] pal(input int idx);
        if (idx == 0) return 24'hF442EE;
        return {8'(idx), 8'(idx ^ 128), 8'(255 - idx)};
    endfunction

    function automatic logic [NL*IW-1:0] pk(input int a, input int b, input int c, input int d);
        return {4'(d), 4'(c), 4'(b), 4'(a)};
    endfunction

    function automatic logic [23:0] model_rgb(input bit v, input int st, input logic [NL-1:0] hit,
                                              input logic [NL*IW-1:0] idx, input bit cur,
                                              input bit sh, input bit flash);
        logic [23:0] c;
        logic [23:0] first = 24'h0000F0;
        bit          found = 1'b0;
        bit          any   = 1'b0;
        if (!v) return 24'h000000;
        if (st == 0) return 24'h00F0F0;
        if (!(st == 1 || st == 2 || st == 4)) return 24'h000000;
        if (cur) return sh ? 24'h000000 : 24'hFFFFFF;
        for (int i = 0; i < NL; i++) begin
            c = pal(int'(idx[i*IW +: IW]));
            if (hit[i] && c != 24'hF442EE) begin
                any = 1'b1;
                if (!found) begin
                    first = c;
                    found = 1'b1;
                end
            end
        end
        if (flash) return any ? 24'hFFFFFF : 24'h000000;
        return first;
    endfunction

    function automatic exp_t blank();
        exp_t e;
        e.v   = 1'b0;
        e.rgb = 24'h000000;
        return e;
    endfunction

    // Drive one pixel, record its expected output, advance one clock and
    // compare the output that belongs to the pixel driven three clocks earlier.
    task automatic drive(input bit v, input bit fs, input int st, input logic [NL-1:0] hit,
                         input logic [NL*IW-1:0] idx, input bit cur, input bit sh);
        bit   flash = 1'b0;
        exp_t e;
        bus.pix_valid   = v;
        bus.frame_start = fs;
        bus.state       = 3'(st);
        bus.layer_hit   = hit;
        bus.layer_idx   = idx;
        bus.is_cursor   = cur;
        bus.shot        = sh;
`ifdef SPRITE_COMPOSITOR_FLASH_EN
        if (v && sh && !shot_prev) flash_cnt = FF;
        else if (fs && flash_cnt > 0) flash_cnt--;
        if (v) shot_prev = sh;
        flash = (flash_cnt > 0);
`endif
        e.v   = v;
        e.rgb = model_rgb(v, st, hit, idx, cur, sh, flash);
        expq.push_back(e);
        @(posedge Clk);
        #1;
        if (expq.size() >= 3) begin
            e = expq.pop_front();
            check("out_valid", {31'd0, bus.out_valid}, {31'd0, e.v});
            check("rgb", {8'd0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, {8'd0, e.rgb});
        end
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        check("rst_out_valid_now", {31'd0, bus.out_valid}, 32'd0);
        check("rst_rgb_now", {8'd0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'd0);
        repeat (2) @(posedge Clk);
        #1;
        check("rst_out_valid_held", {31'd0, bus.out_valid}, 32'd0);
        check("rst_rgb_held", {8'd0, bus.VGA_R, bus.VGA_G, bus.VGA_B}, 32'd0);
        Reset_n   = 1'b1;
        flash_cnt = 0;
        shot_prev = 1'b0;
        expq.delete();
        expq.push_back(blank());
        expq.push_back(blank());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit sh_r = 1'b0;
        int st_r;
        bus.pix_valid   = 1'b0;
        bus.frame_start = 1'b0;
        bus.state       = 3'd0;
        bus.layer_hit   = '0;
        bus.layer_idx   = '0;
        bus.is_cursor   = 1'b0;
        bus.shot        = 1'b0;
        #1;
        do_reset();

        // Title screen ignores layers
        drive(1, 1, 0, 4'hF, pk(1, 2, 3, 4), 0, 0);
        drive(1, 0, 0, 4'hF, pk(5, 6, 7, 8), 1, 0);
        // Priority: layer 1 over 2, key falls through, no hit gives sky
        drive(1, 0, 2, 4'b0110, pk(0, 5, 9, 0), 0, 0);
        drive(1, 0, 2, 4'b0110, pk(0, 0, 9, 0), 0, 0);
        drive(1, 0, 2, 4'b0000, pk(3, 5, 9, 2), 0, 0);
        drive(1, 0, 4, 4'b1000, pk(0, 0, 0, 15), 0, 0);
        // Cursor overrides opaque layer 0
        drive(1, 0, 2, 4'b0001, pk(7, 0, 0, 0), 1, 0);
        drive(1, 0, 2, 4'b0001, pk(7, 0, 0, 0), 1, 1);
        drive(1, 0, 2, 4'b0001, pk(7, 0, 0, 0), 0, 1);
        drive(1, 0, 3, 4'b0001, pk(7, 0, 0, 0), 0, 0);
        drive(1, 0, 6, 4'b0001, pk(7, 0, 0, 0), 0, 0);
        // Blanking between valid pixels
        drive(1, 0, 2, 4'b0001, pk(4, 0, 0, 0), 0, 0);
        drive(0, 0, 2, 4'b0001, pk(4, 0, 0, 0), 0, 0);
        drive(1, 0, 1, 4'b0001, pk(4, 0, 0, 0), 0, 0);

        // Shot edges and frame pulses (flash window when the feature is built in)
        for (int k = 0; k < 24; k++) begin
            drive(1, (k % 6) == 5, 2, (k % 2) ? 4'b0001 : 4'b0000, pk(3, 5, 0, 0), 0,
                  (k >= 2 && k < 8) || (k >= 10));
        end

        // Reset in the middle of a frame, including during an active flash
        drive(1, 0, 2, 4'b0001, pk(3, 0, 0, 0), 0, 0);
        drive(1, 0, 2, 4'b0001, pk(3, 0, 0, 0), 0, 1);
        drive(1, 0, 2, 4'b0001, pk(3, 0, 0, 0), 0, 1);
        do_reset();
        for (int k = 0; k < 6; k++) begin
            drive(1, 0, 2, 4'b0011, pk(3, 9, 0, 0), 0, 1);
        end

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            if (($urandom % 6) == 0) sh_r = ~sh_r;
            st_r = (($urandom % 3) == 0) ? int'($urandom_range(0, 7)) : 2;
            drive(($urandom % 4) != 0, ($urandom % 25) == 0, st_r, NL'($urandom),
                  (NL*IW)'($urandom), ($urandom % 8) == 0, sh_r);
            if (n == 300) do_reset();
        end

        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 2, '0, '0, 0, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameter NUM_LAYERS, default 4: number of sprite layers; layer 0 has highest priority.
REQ-002 Parameter IDX_W, default 4: palette index width per layer.
REQ-003 Parameter FLASH_FRAMES, default 2: length of the shot flash, in frames.
REQ-004 Port Clk, input, 1: the single clock; all state is rising-edge.
REQ-005 Port Reset_n, input, 1: asynchronous, active-low reset.
REQ-006 Port pix_valid, input, 1: DrawX/DrawY/layer inputs are valid this cycle.
REQ-007 Port frame_start, input, 1: one-cycle pulse at the first pixel of each frame.
REQ-008 Port state, input, 3: game screen state, encoded per the package.
REQ-009 Port layer_hit, input, NUM_LAYERS: bit i set means the current pixel lies inside sprite i's bounding box.
REQ-010 Port layer_idx, input, NUM_LAYERS*IDX_W: packed palette index per layer, slice i is layer i.
REQ-011 Port is_cursor, input, 1: the current pixel lies on the crosshair.
REQ-012 Port shot, input, 1: trigger level, sampled on every pixel_valid cycle.
REQ-013 Port VGA_R, VGA_G, VGA_B, output, 8 each: registered pixel colour.
REQ-014 Port out_valid, output, 1: pix_valid delayed to align with the RGB outputs.

Function
REQ-015 The pipeline SHALL have three stages (input register, palette lookup, select/output register), so RGB and out_valid appear exactly 3 cycles after the matching pix_valid.
REQ-016 The pipeline SHALL be free-running with no stall; out_valid SHALL equal pix_valid delayed by 3 cycles.
REQ-017 Stage 2 SHALL look up all NUM_LAYERS indices in parallel in a synchronous palette with 1-cycle read latency.
REQ-018 Stage 2 SHALL carry layer_hit, is_cursor, shot and state through the stage alongside the lookup.
REQ-019 A layer SHALL be opaque at a pixel when its hit bit is set and its palette colour differs from KEY_COLOR (24'hF442EE).
REQ-020 In the GAME states (TITLE_GO, GAME, ROUND_END), the colour SHALL be chosen by this priority: cursor pixel first (24'h000000 if shot, else 24'hFFFFFF); then the lowest-numbered opaque layer; then BG_SKY (24'h0000F0).
REQ-021 In state TITLE, the output SHALL be 24'h00F0F0 regardless of layer inputs.
REQ-022 In state GAME_OVER and in any unlisted encoding, the output SHALL be 24'h000000.
REQ-023 When pix_valid is 0 in stage 3, RGB SHALL be registered as 24'h000000 (blanking).
REQ-024 The shot edge detector SHALL register shot on pix_valid cycles; a rising edge is a 0-to-1 change between consecutive valid samples.
REQ-025 Layer inputs whose bits lie beyond NUM_LAYERS SHALL not exist; NUM_LAYERS=1 SHALL be legal.
REQ-026 A state change mid-frame SHALL take effect on the pixel whose inputs carry the new state, with no frame-boundary deferral.

Reset
REQ-027 On Reset_n low, the following SHALL clear asynchronously: all pipeline valid bits, RGB (to 0), the shot edge register, and the flash counter.
REQ-028 Reset deasserted mid-frame SHALL produce out_valid 0 for at least 3 cycles, after which normal pixels resume with no residue.

Configuration
REQ-029 With macro SPRITE_COMPOSITOR_FLASH_EN defined, a shot rising edge SHALL load the flash counter with FLASH_FRAMES.
REQ-030 With the macro defined, each frame_start SHALL decrement a nonzero flash counter.
REQ-031 With the macro defined, while the flash counter is nonzero in a GAME state, non-cursor pixels SHALL output 24'hFFFFFF if any layer is opaque, else 24'h000000 (hit-detect frame).
REQ-032 A shot edge during an active flash SHALL reload the counter.
REQ-033 Without SPRITE_COMPOSITOR_FLASH_EN, no flash counter SHALL exist and REQ-020 SHALL always apply.

Structure
REQ-034 Package sprite_pkg SHALL hold the screen_state_t enum (TITLE=0, TITLE_GO=1, GAME=2, GAME_OVER=3, ROUND_END=4), KEY_COLOR, BG_SKY, BG_TITLE and the rgb_t typedef (24 bits).
REQ-035 Sub-module palette_lut (synchronous, 1 cycle, 2^IDX_W entries of rgb_t) SHALL be instantiated NUM_LAYERS times via generate.

Verification
REQ-036 Title: state=0, layer_hit all set -> RGB 00F0F0 three cycles after pix_valid.
REQ-037 Priority: state=2, layers 1 and 2 hit with opaque indices -> layer 1 colour; make layer 1 index map to KEY -> layer 2 colour; no hit -> 0000F0.
REQ-038 Cursor: is_cursor=1, shot=0 -> FFFFFF; shot=1 -> 000000, overriding opaque layer 0.
REQ-039 Flash (macro on, FLASH_FRAMES=2): shot 0->1 -> next pixels white on layer-0 hits, black elsewhere, for 2 frame_start pulses, then normal; a shot edge on the second frame extends to 2 more frames.
REQ-040 Blanking/latency: pix_valid toggling 1,0,1 -> out_valid 1,0,1 at +3 cycles, with RGB 000000 on the 0 cycle.
REQ-041 Reset: assert Reset_n low mid-frame -> RGB and out_valid 0 immediately; flash counter clear; first valid output 3 cycles after release.
